// File: rtl/hydro_tdoa_capture.sv
// Hydrophone time-difference-of-arrival capture: measures ticks between channel A/B rising edges after arm.
// Optional HYDRO_TDOA_AUTOREARM_EN: HOLDOFF returns to ARMED instead of IDLE for continuous capture.
module hydro_tdoa_capture #(
    parameter int PRESCALE      = 50,
    parameter int TIMEOUT_TICKS = 1000,
    parameter int HOLDOFF_CYC   = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arm,
    input  logic       hit_a,
    input  logic       hit_b,
    output logic [7:0] disp_val,
    output logic       first_b,
    output logic       result_valid,
    output logic       timeout,
    output logic       busy
);

    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int TICK_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int HOLD_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

    localparam logic [PRE_W-1:0]  PRE_MAX    = PRE_W'(PRESCALE - 1);
    localparam logic [TICK_W-1:0] TICK_LIMIT = TICK_W'(TIMEOUT_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(HOLDOFF_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        COUNT   = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         a_pipe_q, a_pipe_d;
    logic [2:0]         b_pipe_q, b_pipe_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [7:0]         delta_q, delta_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               lead_b_q, lead_b_d;
    logic [7:0]         disp_q, disp_d;
    logic               first_b_q, first_b_d;
    logic               timeout_q, timeout_d;
    logic               rv_q, rv_d;

    logic               rise_a, rise_b, opp_rise, pre_wrap;
    logic [PRE_W-1:0]   pre_next;
    logic [TICK_W-1:0]  tick_next;
    logic [7:0]         delta_next;
    state_t             after_holdoff;

    // Pipe bits: [0] metastable stage, [1] synchronized level, [2] previous level for edge detect.
    always_comb begin
        a_pipe_d = {a_pipe_q[1:0], hit_a};
        b_pipe_d = {b_pipe_q[1:0], hit_b};
    end

    assign rise_a   = a_pipe_q[1] & ~a_pipe_q[2];
    assign rise_b   = b_pipe_q[1] & ~b_pipe_q[2];
    assign opp_rise = lead_b_q ? rise_a : rise_b;

    // Counters hold the elapsed cycles N of the current cycle as tick*PRESCALE + pre.
    always_comb begin
        pre_wrap   = (pre_q == PRE_MAX);
        pre_next   = pre_wrap ? '0 : pre_q + 1'b1;
        tick_next  = pre_wrap ? tick_q + 1'b1 : tick_q;
        delta_next = (pre_wrap && delta_q != 8'hFF) ? delta_q + 8'd1 : delta_q;
    end

`ifdef HYDRO_TDOA_AUTOREARM_EN
    assign after_holdoff = ARMED;
`else
    assign after_holdoff = IDLE;
`endif

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        tick_d    = tick_q;
        delta_d   = delta_q;
        hold_d    = hold_q;
        lead_b_d  = lead_b_q;
        disp_d    = disp_q;
        first_b_d = first_b_q;
        timeout_d = timeout_q;
        rv_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (rise_a && rise_b) begin
                    disp_d    = 8'd0;
                    first_b_d = 1'b0;
                    timeout_d = 1'b0;
                    rv_d      = 1'b1;
                    hold_d    = '0;
                    state_d   = HOLDOFF;
                end else if (rise_a || rise_b) begin
                    lead_b_d = rise_b;
                    pre_d    = pre_next;
                    tick_d   = tick_next;
                    delta_d  = delta_next;
                    state_d  = COUNT;
                end
            end
            COUNT: begin
                if (opp_rise || (tick_q == TICK_LIMIT && pre_q == '0)) begin
                    disp_d    = opp_rise ? delta_q : 8'hFF;
                    timeout_d = ~opp_rise;
                    first_b_d = lead_b_q;
                    rv_d      = 1'b1;
                    pre_d     = '0;
                    tick_d    = '0;
                    delta_d   = 8'd0;
                    hold_d    = '0;
                    state_d   = HOLDOFF;
                end else begin
                    pre_d   = pre_next;
                    tick_d  = tick_next;
                    delta_d = delta_next;
                end
            end
            HOLDOFF: begin
                if (hold_q == HOLD_MAX) begin
                    hold_d  = '0;
                    state_d = after_holdoff;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_pipe_q  <= '0;
            b_pipe_q  <= '0;
            pre_q     <= '0;
            tick_q    <= '0;
            delta_q   <= 8'd0;
            hold_q    <= '0;
            lead_b_q  <= 1'b0;
            disp_q    <= 8'd0;
            first_b_q <= 1'b0;
            timeout_q <= 1'b0;
            rv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_pipe_q  <= a_pipe_d;
            b_pipe_q  <= b_pipe_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            delta_q   <= delta_d;
            hold_q    <= hold_d;
            lead_b_q  <= lead_b_d;
            disp_q    <= disp_d;
            first_b_q <= first_b_d;
            timeout_q <= timeout_d;
            rv_q      <= rv_d;
        end
    end

    assign disp_val     = disp_q;
    assign first_b      = first_b_q;
    assign result_valid = rv_q;
    assign timeout      = timeout_q;
    assign busy         = (state_q != IDLE);

endmodule
